// File: rtl/ram_port_arbiter_if.sv
// Client request/response handshakes plus the RAM-side pins of the two-client RAM arbiter.
// master = clients and RAM model, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              ram_wr;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_out;

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_wr, ram_address, ram_data,
    output ram_out
  );

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_wr, ram_address, ram_data,
    input  ram_out
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter serialising two clients onto one single-port RAM; accept N, write commits end of N+1, rsp in N+3.
// Backpressure: ready only in IDLE and only to the grantee; the losing client holds valid until served.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              pend_wr;
  logic              grant_any;
  logic              grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Under contention the client that was not served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_wr    = grant_id ? bus.req1_wr    : bus.req0_wr;
    sel_addr  = grant_id ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = grant_id ? bus.req1_wdata : bus.req0_wdata;
  end

  assign bus.req0_ready = grant_any & ~grant_id;
  assign bus.req1_ready = grant_any &  grant_id;

  // The RAM pins double as the request latch: loaded on acceptance, held until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      pend_wr         <= 1'b0;
      bus.ram_wr      <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      bus.rsp0_valid  <= 1'b0;
      bus.rsp0_rdata  <= '0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp1_rdata  <= '0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner           <= grant_id;
            last_grant      <= grant_id;
            pend_wr         <= sel_wr;
            bus.ram_wr      <= sel_wr;
            bus.ram_address <= sel_addr;
            bus.ram_data    <= sel_wdata;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          bus.ram_wr <= 1'b0;
          state      <= pend_wr ? IDLE : RDCAP;
        end
        RDCAP: begin
          if (owner) begin
            bus.rsp1_valid <= 1'b1;
            bus.rsp1_rdata <= bus.ram_out;
          end else begin
            bus.rsp0_valid <= 1'b1;
            bus.rsp0_rdata <= bus.ram_out;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 64x8 single-port RAM (ports clk, wr, data, address, out).
- Accepts read/write requests from two independent clients over valid/ready handshakes.
- Serialises the requests onto the single RAM port and returns read data to the client that issued the read.
- Sits directly in front of the RAM. It is the only driver of the RAM's wr/address/data inputs.

Parameters:
ADDR_W, 6, RAM address width (depth = 2**ADDR_W)
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, synchronous, active-low
req0_valid  input  1  client 0 request valid
req0_wr  input  1  client 0: 1=write, 0=read
req0_addr  input  ADDR_W  client 0 address
req0_wdata  input  DATA_W  client 0 write data
req0_ready  output  1  client 0 request accepted this cycle
rsp0_valid  output  1  client 0 read data valid (1-cycle pulse)
rsp0_rdata  output  DATA_W  client 0 read data
req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: identical to client 0, for client 1
ram_wr  output  1  to RAM wr
ram_address  output  ADDR_W  to RAM address
ram_data  output  DATA_W  to RAM data
ram_out  input  DATA_W  from RAM out; RAM read data is registered, so ram_out is valid the cycle after the address is presented with ram_wr=0

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values: state=IDLE, ram_wr=0, ram_address=0, ram_data=0, rsp*_valid=0, rsp*_rdata=0, last_grant=1 (client 0 wins the first contention).
- req*_ready is 0 whenever state!=IDLE or rst_n=0.
- FSM states IDLE, ACCESS, RDCAP:
  - IDLE: arbitrate.
    - Only one valid: that client is granted.
    - Both valid: the client != last_grant is granted.
    - reqX_ready=1 (combinational) for the granted client only.
    - On valid&&ready: latch wr/addr/wdata and the grantee ID, update last_grant, go to ACCESS.
    - No valid: stay in IDLE.
  - ACCESS (1 cycle): ram_address=latched addr, ram_data=latched wdata, ram_wr=latched wr (registered outputs).
    - Write: go to IDLE. The RAM write commits at the end of this cycle.
    - Read: go to RDCAP.
  - RDCAP (1 cycle): ram_wr=0. Load ram_out into rspX_rdata of the grantee, set rspX_valid. Go to IDLE.
- rspX_valid is a registered 1-cycle pulse, high in the cycle after RDCAP, which is the next IDLE cycle. It may coincide with a new acceptance.
- rspX_rdata holds its value until that client's next read completes. The other client's rdata is untouched.
- Latency: accept in cycle N, write commits at the end of N+1, read rsp_valid in N+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- ram_wr is 1 only during ACCESS of a write. It is never high in IDLE or RDCAP.
- ram_address and ram_data hold their last values outside ACCESS.
- Handshake rules:
  - A client holds valid and its payload stable until ready.
  - valid must not depend combinationally on ready.
  - A non-granted valid client waits without loss.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Addresses are used as-is (no wrap logic). Address 2**ADDR_W-1 is legal.
- Reset mid-operation: rst_n low at any edge returns to IDLE with reset values.
  - An in-flight read produces no rsp_valid.
  - A write in ACCESS during the reset edge is not guaranteed to commit.
  - ram_wr=0 from the cycle after the reset edge.

Test Plan:
1. Client 0 writes 0x01 @1, 0x03 @0, 0x02 @3, then reads @1, @3, @0 -> rsp0_rdata = 0x01, 0x02, 0x03, each rsp0_valid pulse exactly 3 cycles after its acceptance. rsp1_valid is never asserted.
2. Both clients assert valid in the same cycle after reset (c0 write 0x06 @5, c1 read @5) -> c0 is granted first, c1 is accepted in the following IDLE, rsp1_rdata=0x06.
3. Both clients hold continuous read requests for 8 accepts -> grant order 0,1,0,1,0,1,0,1. No rsp is routed to the wrong client.
4. Client 1 writes 0xA5 @63, then reads @63 -> rsp1_rdata=0xA5. ram_address=63 during both ACCESS cycles.
5. Client 0 read @3 accepted, rst_n=0 during RDCAP -> no rsp0_valid, all outputs at reset values the next cycle. After release, a read @3 returns the pre-reset stored value.
6. Client 0 holds valid while client 1 is mid-read -> req0_ready=0 in ACCESS and RDCAP. req0 is accepted in the next IDLE and its payload is captured unchanged.
